// File: rtl/mgmt_byte_bridge.sv
// mgmt_byte_bridge
// Turns the QSPI-side byte stream into single-byte accesses on the management
// register bus. Every transaction opens with a 2-byte header: bit 15 is the R/W
// flag (1 = read) and bits 14:0 are the start address. Writes then stream data
// bytes to incrementing addresses. Reads prefetch one byte at a time and hand
// each byte to the host. A timeout bounds every register read.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   txn_start, txn_end   chip-select assert / deassert pulses
//   rx_valid, rx_data    received byte from the host
//   tx_valid, tx_ready,
//   tx_data              read byte to the host (held until tx_ready)
//   rd_en, rd_addr       one-cycle read request; rd_addr held while pending
//   rd_valid, rd_data    read response from the register block
//   wr_en, wr_addr,
//   wr_data              one-cycle write strobe with address and data
//   rd_timeout_count     saturating count of reads that timed out
//   busy                 high whenever the bridge is not idle
module mgmt_byte_bridge #(
    parameter int unsigned RD_TIMEOUT   = 255,
    parameter logic [7:0]  TIMEOUT_DATA = 8'hff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        txn_start,
    input  logic        txn_end,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic        rd_valid,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_timeout_count,
    output logic        busy
);

    // The timer is loaded in the cycle that rd_en is driven and counts that
    // cycle, so a timed-out read shows tx_valid exactly RD_TIMEOUT cycles after rd_en.
    localparam logic [15:0] TIMER_LOAD = 16'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WRITE,
        RD_WAIT,
        RD_HOLD,
        RD_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [14:0] addr_q, addr_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] to_count_q, to_count_d;
    logic        start_pend_q, start_pend_d;

    logic        expired;
    logic [15:0] to_count_inc;
    logic        pend_next;

    // A response arriving in the last cycle of the window beats the timeout.
    assign expired      = (timer_q == 16'd1) && !rd_valid;
    assign to_count_inc = (to_count_q == 16'hffff) ? to_count_q : to_count_q + 16'd1;
    // A start seen while a read drains is remembered until the read retires;
    // a later chip-select deassert cancels it unless a start arrives with it.
    assign pend_next    = txn_start || (start_pend_q && !txn_end);

    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        timer_d      = timer_q;
        to_count_d   = to_count_q;
        start_pend_d = start_pend_q;

        case (state_q)
            IDLE: begin
                if (txn_start) begin
                    state_d = ADDR_HI;
                end
            end

            ADDR_HI: begin
                if (txn_start) begin
                    state_d = ADDR_HI;
                end else if (txn_end) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    is_read_d     = rx_data[7];
                    addr_d[14:8]  = rx_data[6:0];
                    state_d       = ADDR_LO;
                end
            end

            ADDR_LO: begin
                if (txn_start) begin
                    state_d = ADDR_HI;
                end else if (txn_end) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    if (is_read_q) begin
                        rd_en_d = 1'b1;
                        timer_d = TIMER_LOAD;
                        state_d = RD_WAIT;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                // A byte received together with start/end is still written.
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {1'b0, addr_q};
                    wr_data_d = rx_data;
                    addr_d    = addr_q + 15'd1;
                end
                if (txn_start) begin
                    state_d = ADDR_HI;
                end else if (txn_end) begin
                    state_d = IDLE;
                end
            end

            RD_WAIT: begin
                if (rd_valid || expired) begin
                    if (expired) begin
                        to_count_d = to_count_inc;
                    end
                    // The read has retired, so no flush is needed on abort.
                    if (txn_start) begin
                        state_d = ADDR_HI;
                    end else if (txn_end) begin
                        state_d = IDLE;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = rd_valid ? rd_data : TIMEOUT_DATA;
                        state_d    = RD_HOLD;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                    if (txn_start) begin
                        start_pend_d = 1'b1;
                        state_d      = RD_FLUSH;
                    end else if (txn_end) begin
                        state_d = RD_FLUSH;
                    end
                end
            end

            RD_HOLD: begin
                if (txn_start) begin
                    tx_valid_d = 1'b0;
                    state_d    = ADDR_HI;
                end else if (txn_end) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (tx_ready) begin
                    // Speculatively fetch the next byte of the burst.
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 15'd1;
                    rd_en_d    = 1'b1;
                    timer_d    = TIMER_LOAD;
                    state_d    = RD_WAIT;
                end
            end

            RD_FLUSH: begin
                if (rd_valid || expired) begin
                    if (expired) begin
                        to_count_d = to_count_inc;
                    end
                    start_pend_d = 1'b0;
                    state_d      = pend_next ? ADDR_HI : IDLE;
                end else begin
                    timer_d      = timer_q - 16'd1;
                    start_pend_d = pend_next;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_read_q    <= 1'b0;
            addr_q       <= 15'd0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 16'd0;
            wr_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            timer_q      <= 16'd0;
            to_count_q   <= 16'd0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_read_q    <= is_read_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            timer_q      <= timer_d;
            to_count_q   <= to_count_d;
            start_pend_q <= start_pend_d;
        end
    end

    // rd_addr comes straight from the address register, which only moves when
    // a new request is issued, so it stays put while a read is outstanding.
    assign rd_addr          = {1'b0, addr_q};
    assign rd_en            = rd_en_q;
    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign tx_valid         = tx_valid_q;
    assign tx_data          = tx_data_q;
    assign rd_timeout_count = to_count_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mgmt_byte_bridge.sv
// Testbench for mgmt_byte_bridge. Inputs change 1 ns after each rising edge and
// outputs are sampled at that same point, so every sample shows the result of
// the inputs applied in the previous cycle. Expected writes, read addresses and
// returned bytes go into queues as stimulus is driven and are popped when the
// DUT produces the matching output.
module tb_mgmt_byte_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        txn_start, txn_end;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_timeout_count;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int exp_timeouts = 0;

    logic [23:0] wr_exp_q[$];
    logic [15:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    mgmt_byte_bridge #(
        .RD_TIMEOUT  (8),
        .TIMEOUT_DATA(8'hFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .txn_start       (txn_start),
        .txn_end         (txn_end),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_timeout_count(rd_timeout_count),
        .busy            (busy)
    );

    // Advance one cycle and land just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Open a read: start pulse plus the two header bytes; the expected first
    // read address is queued before the last header byte goes out
    task automatic start_read(input logic [7:0] h0, input logic [7:0] h1);
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
        send_byte(h0);
        rd_exp_q.push_back({1'b0, h0[6:0], h1});
        send_byte(h1);
    endtask

    // Check the first read request issued right after the header
    task automatic check_first_read();
        logic [15:0] e;
        e = rd_exp_q.pop_front();
        vectors++;
        if ({rd_en, rd_addr} !== {1'b1, e}) begin
            miscompares++;
            $display("[TB] FAIL first_rd_req: got rd_en=%b addr=%h expected rd_en=1 addr=%h", rd_en, rd_addr, e);
        end
    endtask

    // Whole write transaction with two back-to-back data bytes
    task automatic write_txn(input bit with_start, input logic [7:0] h0, input logic [7:0] h1,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic [15:0] a;
        logic [23:0] e;
        logic [7:0]  d[2];
        if (with_start) begin
            txn_start = 1'b1;
            tick();
            txn_start = 1'b0;
        end
        send_byte(h0);
        send_byte(h1);
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_during_header: got wr_en=%b expected 0", wr_en);
        end
        a    = {1'b0, h0[6:0], h1};
        d[0] = d0;
        d[1] = d1;
        for (int i = 0; i < 2; i++) begin
            wr_exp_q.push_back({a, d[i]});
            a = {1'b0, a[14:0] + 15'd1};
            rx_valid = 1'b1;
            rx_data  = d[i];
            tick();
            rx_valid = 1'b0;
            e = wr_exp_q.pop_front();
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, e}) begin
                miscompares++;
                $display("[TB] FAIL write_%0d: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
                         i, wr_en, wr_addr, wr_data, e[23:8], e[7:0]);
            end
        end
        txn_end = 1'b1;
        tick();
        txn_end = 1'b0;
        vectors++;
        if ({wr_en, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL write_end: got wr_en=%b busy=%b expected 0 0", wr_en, busy);
        end
    endtask

    // Outputs must be zero while reset is held and just after release
    task automatic test_reset();
        #1;
        vectors++;
        if ({tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_timeout_count, busy} !== 68'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_timeout_count, busy});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({tx_valid, rd_en, wr_en, busy, rd_timeout_count} !== 20'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %h expected 0", {tx_valid, rd_en, wr_en, busy, rd_timeout_count});
        end
    endtask

    task automatic test_write_burst();
        write_txn(1'b1, 8'h40, 8'h00, 8'h12, 8'h0A);
    endtask

    task automatic test_wrap();
        write_txn(1'b1, 8'h7F, 8'hFF, 8'hA1, 8'hB2);
    endtask

    // A start in ADDR_LO throws away the half-received header
    task automatic test_start_overrides();
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
        send_byte(8'h55);
        write_txn(1'b1, 8'h12, 8'h34, 8'hC3, 8'h3C);
    endtask

    // Three-byte read burst, responder answers 3 cycles after each request
    task automatic test_read_burst();
        logic [7:0]  resp[3];
        logic [15:0] e;
        logic [15:0] ea;
        logic [7:0]  et;
        resp[0] = 8'h11;
        resp[1] = 8'h22;
        resp[2] = 8'h33;
        start_read(8'h80, 8'h04);
        check_first_read();
        e = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                vectors++;
                if ({rd_en, tx_valid, rd_addr} !== {2'b00, e}) begin
                    miscompares++;
                    $display("[TB] FAIL rd_wait_%0d: got rd_en=%b tx_valid=%b addr=%h expected 0 0 %h",
                             i, rd_en, tx_valid, rd_addr, e);
                end
            end
            rd_valid = 1'b1;
            rd_data  = resp[i];
            tx_exp_q.push_back(resp[i]);
            tick();
            rd_valid = 1'b0;
            vectors++;
            if (tx_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rd_to_tx_latency_%0d: got tx_valid=%b expected 1", i, tx_valid);
            end
            tick();
            et = tx_exp_q.pop_front();
            vectors++;
            if ({tx_valid, tx_data} !== {1'b1, et}) begin
                miscompares++;
                $display("[TB] FAIL tx_hold_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, et);
            end
            e = {1'b0, e[14:0] + 15'd1};
            rd_exp_q.push_back(e);
            tx_ready = 1'b1;
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            tick();
            tx_ready = 1'b0;
            rx_valid = 1'b0;
            ea = rd_exp_q.pop_front();
            vectors++;
            if ({tx_valid, rd_en, rd_addr, wr_en} !== {1'b0, 1'b1, ea, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL prefetch_%0d: got tx_valid=%b rd_en=%b addr=%h wr_en=%b expected 0 1 %h 0",
                         i, tx_valid, rd_en, rd_addr, wr_en, ea);
            end
        end
        // End the transaction with the speculative read to 0x0007 pending
        txn_end = 1'b1;
        tick();
        txn_end = 1'b0;
        tick();
        vectors++;
        if ({busy, tx_valid, rd_addr} !== {2'b10, 16'h0007}) begin
            miscompares++;
            $display("[TB] FAIL flush_hold: got busy=%b tx_valid=%b addr=%h expected 1 0 0007", busy, tx_valid, rd_addr);
        end
        rd_valid = 1'b1;
        rd_data  = 8'h44;
        tick();
        rd_valid = 1'b0;
        vectors++;
        if ({busy, tx_valid, rd_en, rd_timeout_count} !== {3'b000, 16'(exp_timeouts)}) begin
            miscompares++;
            $display("[TB] FAIL flush_exit: got busy=%b tx_valid=%b rd_en=%b cnt=%0d expected 0 0 0 %0d",
                     busy, tx_valid, rd_en, rd_timeout_count, exp_timeouts);
        end
    endtask

    // Timeout with no response, then a response right on the expiry cycle
    task automatic test_timeout();
        int          n;
        logic [15:0] ea;
        start_read(8'h80, 8'h10);
        check_first_read();
        n = 0;
        do begin
            tick();
            n++;
        end while (tx_valid !== 1'b1 && n < 20);
        exp_timeouts++;
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected 8", n);
        end
        vectors++;
        if ({tx_data, rd_timeout_count} !== {8'hFF, 16'(exp_timeouts)}) begin
            miscompares++;
            $display("[TB] FAIL timeout_data: got data=%h cnt=%0d expected ff %0d", tx_data, rd_timeout_count, exp_timeouts);
        end
        rd_exp_q.push_back(16'h0011);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        ea = rd_exp_q.pop_front();
        vectors++;
        if ({rd_en, rd_addr} !== {1'b1, ea}) begin
            miscompares++;
            $display("[TB] FAIL timeout_next_req: got rd_en=%b addr=%h expected 1 %h", rd_en, rd_addr, ea);
        end
        for (int k = 0; k < 7; k++) begin
            tick();
            vectors++;
            if (tx_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL early_tx_%0d: got tx_valid=%b expected 0", k, tx_valid);
            end
        end
        rd_valid = 1'b1;
        rd_data  = 8'h5A;
        tick();
        rd_valid = 1'b0;
        vectors++;
        if ({tx_valid, tx_data, rd_timeout_count} !== {1'b1, 8'h5A, 16'(exp_timeouts)}) begin
            miscompares++;
            $display("[TB] FAIL expiry_cycle_data: got valid=%b data=%h cnt=%0d expected 1 5a %0d",
                     tx_valid, tx_data, rd_timeout_count, exp_timeouts);
        end
        txn_end = 1'b1;
        tick();
        txn_end = 1'b0;
        vectors++;
        if ({busy, tx_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL hold_end: got busy=%b tx_valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    // End then start while a read is pending; response arrives 5 cycles later
    task automatic test_abort();
        start_read(8'h80, 8'h20);
        check_first_read();
        for (int c = 0; c < 5; c++) begin
            txn_end   = (c == 0);
            txn_start = (c == 1);
            rx_valid  = (c == 2);
            rx_data   = 8'hEE;
            tick();
            txn_end   = 1'b0;
            txn_start = 1'b0;
            rx_valid  = 1'b0;
            vectors++;
            if ({busy, tx_valid, rd_en, wr_en, rd_addr} !== {4'b1000, 16'h0020}) begin
                miscompares++;
                $display("[TB] FAIL abort_flush_%0d: got busy=%b tx=%b rd_en=%b wr_en=%b addr=%h expected 1 0 0 0 0020",
                         c, busy, tx_valid, rd_en, wr_en, rd_addr);
            end
        end
        rd_valid = 1'b1;
        rd_data  = 8'h77;
        tick();
        rd_valid = 1'b0;
        vectors++;
        if ({busy, tx_valid, rd_en, rd_timeout_count} !== {3'b100, 16'(exp_timeouts)}) begin
            miscompares++;
            $display("[TB] FAIL abort_exit: got busy=%b tx=%b rd_en=%b cnt=%0d expected 1 0 0 %0d",
                     busy, tx_valid, rd_en, rd_timeout_count, exp_timeouts);
        end
        // The pending start left the bridge waiting for a header
        write_txn(1'b0, 8'h01, 8'h23, 8'h9C, 8'h9D);
    endtask

    // Asynchronous reset while a byte is held for the host
    task automatic test_reset_mid();
        start_read(8'h80, 8'h30);
        check_first_read();
        rd_valid = 1'b1;
        rd_data  = 8'h44;
        tick();
        rd_valid = 1'b0;
        vectors++;
        if (tx_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_hold: got tx_valid=%b expected 1", tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_timeouts = 0;
        vectors++;
        if ({tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_timeout_count, busy} !== 68'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected 0",
                     {tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_timeout_count, busy});
        end
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if ({busy, tx_valid, rd_en, wr_en} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got busy=%b tx=%b rd_en=%b wr_en=%b expected 0", busy, tx_valid, rd_en, wr_en);
        end
        write_txn(1'b1, 8'h22, 8'h00, 8'h01, 8'h02);
    endtask

    // Run every scenario in order and print the summary
    initial begin
        rst_n     = 1'b0;
        txn_start = 1'b0;
        txn_end   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 8'h00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_timeout();
        test_wrap();
        test_start_overrides();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
